// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the non-restoring divider and its
//                recombination (quotient*divisor+remainder) checker: FSM
//                state encoding, default operand widths, counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default dividend/quotient and divisor/remainder widths
  localparam int c_DVD_W = 32;
  localparam int c_DVS_W = 16;

  // Iteration counter must reach DVS_W, hence one bit beyond the index width
  function automatic int cnt_width(input int dvs_w);
    return $clog2(dvs_w) + 1;
  endfunction

  localparam int c_CNT_W = cnt_width(c_DVS_W);

  // Three-state sequencer shared with the divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_recombine.sv
`default_nettype none
// ============================================================================
//  Module      : div_recombine
//  Description : Sequential shift-add rebuild of dividend = quotient*divisor
//                (+ remainder when mode=0), one divisor bit per cycle, with
//                the divider's valid_in/busy/valid_out handshake. ovf flags a
//                sum wider than DVD_W. Optional macro RECOMB_CHECK_EN enables
//                the remainder>=divisor check on rem_err; otherwise rem_err
//                is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_recombine
  import div_pkg::*;
#(
  parameter int DVD_W = c_DVD_W,
  parameter int DVS_W = c_DVS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             mode,
  input  logic [DVD_W-1:0] quotient,
  input  logic [DVS_W-1:0] divisor,
  input  logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             valid_out,
  output logic [DVD_W-1:0] result,
  output logic             ovf,
  output logic             rem_err
);

  // Accumulator holds the full product plus addend carry: never truncates
  localparam int c_ACC_W = DVD_W + DVS_W + 1;
  localparam int c_CNT_W = cnt_width(DVS_W);
  localparam int c_IDX_W = c_CNT_W - 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DVS_W - 1);

  div_state_t           r_state;
  div_state_t           w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DVD_W-1:0]     r_q;
  logic [DVS_W-1:0]     r_d;
  logic [DVS_W-1:0]     r_r;
  logic                 r_mode;
  logic [c_ACC_W-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_valid_out;
  logic [DVD_W-1:0]     r_result;
  logic                 r_ovf;

  logic [c_IDX_W-1:0]   w_idx;
  logic [c_ACC_W-1:0]   w_shifted;
  logic [c_ACC_W-1:0]   w_sum;

  assign w_idx     = r_cnt[c_IDX_W-1:0];
  assign w_shifted = c_ACC_W'(r_q) << r_cnt;
  assign w_sum     = r_acc + (r_mode ? '0 : c_ACC_W'(r_r));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, leave RUN after the last divisor bit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_in) w_state_nxt = RUN;
      RUN:     if (r_cnt == c_LAST) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result registration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_mode      <= 1'b0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_valid_out <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid_out <= 1'b0;
          if (valid_in) begin
            r_q    <= quotient;
            r_d    <= divisor;
            r_r    <= remainder;
            r_mode <= mode;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          if (r_d[w_idx]) r_acc <= r_acc + w_shifted;
          r_cnt <= r_cnt + 1'b1;
        end
        FIN: begin
          r_result    <= w_sum[DVD_W-1:0];
          r_ovf       <= |w_sum[c_ACC_W-1:DVD_W];
          r_valid_out <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_valid_out <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RECOMB_CHECK_EN
  logic r_rem_err;

  // Remainder sanity flag, registered alongside the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_rem_err <= 1'b0;
    else if (r_state == FIN) r_rem_err <= (r_r >= r_d);
  end

  assign rem_err = r_rem_err;
`else
  assign rem_err = 1'b0;
`endif

  assign busy      = r_busy;
  assign valid_out = r_valid_out;
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_div_recombine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_recombine
//  Description : Self-checking bench for div_recombine: directed corner cases,
//                back-to-back handshake, async reset abort and random operands
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_recombine;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        mode;
  logic [31:0] quotient;
  logic [15:0] divisor;
  logic [15:0] remainder;
  logic        busy;
  logic        valid_out;
  logic [31:0] result;
  logic        ovf;
  logic        rem_err;

  int n_pass  = 0;
  int n_total = 0;

  div_recombine dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .mode      (mode),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .valid_out (valid_out),
    .result    (result),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: plain unsigned arithmetic on 64-bit integers
  function automatic logic [63:0] ref_sum(input logic [31:0] q, input logic [15:0] d,
                                          input logic [15:0] r, input logic m);
    return 64'(q) * 64'(d) + (m ? 64'd0 : 64'(r));
  endfunction

  function automatic logic ref_rem_err(input logic [15:0] d, input logic [15:0] r);
`ifdef RECOMB_CHECK_EN
    return r >= d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_result(input string tag, input logic [31:0] q, input logic [15:0] d,
                              input logic [15:0] r, input logic m);
    logic [63:0] s;
    s = ref_sum(q, d, r, m);
    check({tag, ".result"}, 64'(result), 64'(s[31:0]));
    check({tag, ".ovf"}, 64'(ovf), 64'(s[63:32] != 32'd0));
    check({tag, ".rem_err"}, 64'(rem_err), 64'(ref_rem_err(d, r)));
  endtask

  // Wait for valid_out, sampling #1 after each edge; returns edges elapsed and busy cycles
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 1;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (valid_out) break;
      if (busy) bcnt++;
    end
  endtask

  // One full request; inputs are scrambled after acceptance to prove capture
  task automatic run_op(input string tag, input logic [31:0] q, input logic [15:0] d,
                        input logic [15:0] r, input logic m, input bit chk_timing);
    int cyc, bcnt;
    @(negedge clk);
    valid_in = 1'b1; quotient = q; divisor = d; remainder = r; mode = m;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    quotient  = $urandom;
    divisor   = 16'($urandom);
    remainder = 16'($urandom);
    mode      = 1'($urandom);
    wait_done(cyc, bcnt);
    if (chk_timing) begin
      check({tag, ".latency"}, 64'(cyc), 64'd17);
      check({tag, ".busy_cycles"}, 64'(bcnt), 64'd17);
    end else if (cyc >= 40) begin
      check({tag, ".timeout"}, 64'(cyc), 64'd17);
    end
    check_result(tag, q, d, r, m);
    @(posedge clk);
    #1;
    if (chk_timing) check({tag, ".valid_out_pulse"}, 64'(valid_out), 64'd0);
  endtask

  initial begin
    int cyc, bcnt;
    logic [31:0] qa, qb;
    logic [15:0] da, db, ra, rb;
    logic        ma, mb;

    reset = 1'b0; valid_in = 1'b0; mode = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.valid_out", 64'(valid_out), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.ovf", 64'(ovf), 64'd0);
    check("reset.rem_err", 64'(rem_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_op("t1", 32'd3, 16'd5, 16'd2, 1'b0, 1'b1);
    check("t1.exp17", 64'(result), 64'd17);
    run_op("t2", 32'd3, 16'd5, 16'd2, 1'b1, 1'b1);
    check("t2.exp15", 64'(result), 64'd15);
    run_op("t3", 32'hFFFF_FFFF, 16'hFFFF, 16'd0, 1'b1, 1'b1);
    check("t3.exp", 64'(result), 64'hFFFF_0001);
    check("t3.ovf1", 64'(ovf), 64'd1);
    run_op("t4", 32'd7, 16'd0, 16'd4, 1'b0, 1'b1);
    check("t4.exp4", 64'(result), 64'd4);

    // Back-to-back with valid_in held high
    qa = $urandom; da = 16'($urandom); ra = 16'($urandom); ma = 1'b0;
    qb = $urandom; db = 16'($urandom); rb = 16'($urandom); mb = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; quotient = qa; divisor = da; remainder = ra; mode = ma;
    @(posedge clk);
    cyc = 0;
    while (cyc < 40) begin
      #1;
      quotient = $urandom; divisor = 16'($urandom);
      remainder = 16'($urandom); mode = 1'($urandom);
      @(posedge clk);
      cyc++;
      #1;
      if (valid_out) break;
    end
    check("b2b.first_latency", 64'(cyc), 64'd17);
    check_result("b2b.first", qa, da, ra, ma);
    quotient = qb; divisor = db; remainder = rb; mode = mb;
    @(posedge clk);
    #1;
    check("b2b.accept_busy", 64'(busy), 64'd1);
    check("b2b.accept_vout", 64'(valid_out), 64'd0);
    valid_in = 1'b0;
    quotient = $urandom; divisor = 16'($urandom);
    repeat (5) @(posedge clk);
    #1;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check_result("b2b.held", qa, da, ra, ma);
    cyc = 6;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (valid_out) break;
    end
    check("b2b.second_latency", 64'(cyc), 64'd17);
    check_result("b2b.second", qb, db, rb, mb);
    @(posedge clk);
    #1;
    check("b2b.no_third", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    valid_in = 1'b1; quotient = 32'd9; divisor = 16'd9; remainder = 16'd20; mode = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.valid_out", 64'(valid_out), 64'd0);
    check("arst.result", 64'(result), 64'd0);
    check("arst.ovf", 64'(ovf), 64'd0);
    check("arst.rem_err", 64'(rem_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("arst.after", 32'd3, 16'd5, 16'd2, 1'b0, 1'b1);
    check("arst.exp17", 64'(result), 64'd17);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      logic [31:0] q;
      logic [15:0] d, r;
      q = $urandom;
      d = (i % 3 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      r = 16'($urandom);
      run_op($sformatf("rnd%0d", i), q, d, r, 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
